// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller:
// state encoding, the blank segment pattern and the hex decode table.
package seg_pkg;

   typedef enum logic [1:0] {
      OFF  = 2'd0,
      BLNK = 2'd1,
      DRV  = 2'd2
   } state_t;

   localparam logic [6:0] SEG_OFF = 7'b1111111;

   // Active-low gfedcba patterns for hex digits 0..F
   localparam logic [6:0] SEG_LUT [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

endpackage

// File: rtl/seg_scan_ctrl_segout.sv
// Hex-to-seven-segment decoder shared by every digit position of the scan.
// Purely combinational; the controller registers and blanks its output.
module segout
   import seg_pkg::*;
(
   input  logic [3:0] i_hex,
   output logic [6:0] o_seg
);

   assign o_seg = SEG_LUT[i_hex];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for NDIG common-anode digits on one segment bus.
// Loads are staged and only committed at frame boundaries so a frame never mixes values.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int NDIG  = 4,
   parameter int DIV   = 50000,
   parameter int BLANK = 2000
)
(
   input  logic              iCLK,
   input  logic              iRST_N,
   input  logic              iEN,
   input  logic [4*NDIG-1:0] iDATA,
   input  logic [NDIG-1:0]   iMASK,
   input  logic              iLOAD,
   output logic              oBUSY,
   output logic              oACK,
   output logic              oFRAME,
   output logic [NDIG-1:0]   oAN,
   output logic [6:0]        oSEG
);

   localparam int CW = $clog2(DIV);
   localparam int IW = $clog2(NDIG);

   localparam logic [CW-1:0] CNT_BLK_LAST = CW'(BLANK - 1);
   localparam logic [CW-1:0] CNT_LAST     = CW'(DIV - 1);
   localparam logic [IW-1:0] IDX_LAST     = IW'(NDIG - 1);

   state_t              r_state;
   logic [CW-1:0]       r_cnt;
   logic [IW-1:0]       r_idx;
   logic [4*NDIG-1:0]   r_shData;
   logic [NDIG-1:0]     r_shMask;
   logic [4*NDIG-1:0]   r_stData;
   logic [NDIG-1:0]     r_stMask;
   logic                r_pend;
   logic                r_commit;

   logic [NDIG-1:0]     r_an;
   logic [6:0]          r_seg;
   logic                r_frame;
   logic                r_ack;
   logic                r_busy;

   logic [3:0]          w_nibble;
   logic                w_masked;
   logic [6:0]          w_decSeg;
   logic [NDIG-1:0]     w_anNext;
   logic [6:0]          w_segNext;
   logic                w_frameEdge;

   // Select the shadow nibble and mask bit for the digit currently being scanned
   always_comb begin
      w_nibble = '0;
      w_masked = 1'b1;
      for (int k = 0; k < NDIG; k++) begin
         if (r_idx == IW'(k)) begin
            w_nibble = r_shData[4*k +: 4];
            w_masked = r_shMask[k];
         end
      end
   end

   segout u_segout (
      .i_hex (w_nibble),
      .o_seg (w_decSeg)
   );

   always_comb begin
      w_anNext = '1;
      for (int k = 0; k < NDIG; k++) begin
         if (r_state == DRV && r_idx == IW'(k) && !r_shMask[k]) begin
            w_anNext[k] = 1'b0;
         end
      end
   end

   assign w_segNext = (r_state == DRV && !w_masked) ? w_decSeg : SEG_OFF;

   // Leaving the last slot of a frame and waking from OFF both start a new frame
   assign w_frameEdge = iEN &&
                        ((r_state == OFF) || (r_cnt == CNT_LAST && r_idx == IDX_LAST));

   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         r_state  <= OFF;
         r_cnt    <= '0;
         r_idx    <= '0;
         r_shData <= '0;
         r_shMask <= '1;
         r_stData <= '0;
         r_stMask <= '0;
         r_pend   <= 1'b0;
         r_commit <= 1'b0;
         r_an     <= '1;
         r_seg    <= SEG_OFF;
         r_frame  <= 1'b0;
         r_ack    <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_commit <= 1'b0;

         if (iLOAD) begin
            r_stData <= iDATA;
            r_stMask <= iMASK;
            r_pend   <= 1'b1;
         end

         // A load on the boundary cycle goes straight to the shadow registers
         if (w_frameEdge) begin
            if (iLOAD) begin
               r_shData <= iDATA;
               r_shMask <= iMASK;
               r_pend   <= 1'b0;
               r_commit <= 1'b1;
            end else if (r_pend) begin
               r_shData <= r_stData;
               r_shMask <= r_stMask;
               r_pend   <= 1'b0;
               r_commit <= 1'b1;
            end
         end

         if (!iEN) begin
            r_state <= OFF;
            r_cnt   <= '0;
            r_idx   <= '0;
         end else begin
            case (r_state)
               OFF: begin
                  r_state <= BLNK;
                  r_cnt   <= '0;
                  r_idx   <= '0;
               end
               BLNK: begin
                  if (r_cnt == CNT_BLK_LAST) begin
                     r_state <= DRV;
                  end
                  r_cnt <= r_cnt + CW'(1);
               end
               DRV: begin
                  if (r_cnt == CNT_LAST) begin
                     r_state <= BLNK;
                     r_cnt   <= '0;
                     r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
                  end else begin
                     r_cnt <= r_cnt + CW'(1);
                  end
               end
               default: begin
                  r_state <= OFF;
                  r_cnt   <= '0;
                  r_idx   <= '0;
               end
            endcase
         end

         r_an    <= w_anNext;
         r_seg   <= w_segNext;
         r_frame <= (r_state == BLNK) && (r_cnt == '0) && (r_idx == '0);
         r_ack   <= r_commit;
         r_busy  <= r_pend;
      end
   end

   assign oAN    = r_an;
   assign oSEG   = r_seg;
   assign oFRAME = r_frame;
   assign oACK   = r_ack;
   assign oBUSY  = r_busy;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a frame-position reference model predicts
// every cycle's outputs into a queue that an independent monitor drains.
module tb_seg_scan_ctrl;

   localparam int NDIG  = 4;
   localparam int DIV   = 8;
   localparam int BLANK = 2;
   localparam int FRAME = NDIG * DIV;

   logic        iCLK = 1'b0;
   logic        iRST_N;
   logic        iEN;
   logic [15:0] iDATA;
   logic [3:0]  iMASK;
   logic        iLOAD;
   logic        oBUSY;
   logic        oACK;
   logic        oFRAME;
   logic [3:0]  oAN;
   logic [6:0]  oSEG;

   always #5 iCLK = ~iCLK;

   seg_scan_ctrl #(
      .NDIG  (NDIG),
      .DIV   (DIV),
      .BLANK (BLANK)
   ) dut (
      .iCLK   (iCLK),
      .iRST_N (iRST_N),
      .iEN    (iEN),
      .iDATA  (iDATA),
      .iMASK  (iMASK),
      .iLOAD  (iLOAD),
      .oBUSY  (oBUSY),
      .oACK   (oACK),
      .oFRAME (oFRAME),
      .oAN    (oAN),
      .oSEG   (oSEG)
   );

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       frame;
      logic       ack;
      logic       busy;
   } exp_t;

   exp_t expQ[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   cycle       = 0;

   logic [6:0] segTable [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   // Reference model: position within the frame plus the visible/pending values
   bit          mRunning = 0;
   int          mPos     = 0;
   logic [15:0] mShData  = '0;
   logic [3:0]  mShMask  = '1;
   logic [15:0] mStData  = '0;
   logic [3:0]  mStMask  = '0;
   bit          mPend    = 0;
   bit          mAckNext = 0;

   function automatic exp_t predictOutputs(input bit rstN);
      exp_t e;
      int   slot;
      int   phase;
      e.an    = 4'hF;
      e.seg   = 7'h7F;
      e.frame = 1'b0;
      e.ack   = 1'b0;
      e.busy  = 1'b0;
      if (rstN) begin
         slot  = mPos / DIV;
         phase = mPos % DIV;
         if (mRunning && phase >= BLANK && !mShMask[slot]) begin
            e.an  = ~(4'b0001 << slot);
            e.seg = segTable[mShData[slot*4 +: 4]];
         end
         e.frame = mRunning && (mPos == 0);
         e.ack   = mAckNext;
         e.busy  = mPend;
      end
      return e;
   endfunction

   task automatic modelStep(input bit rstN, input bit en, input bit load,
                            input logic [15:0] data, input logic [3:0] mask);
      bit commit;
      bit boundary;
      if (!rstN) begin
         mRunning = 0;
         mPos     = 0;
         mShData  = '0;
         mShMask  = '1;
         mStData  = '0;
         mStMask  = '0;
         mPend    = 0;
         mAckNext = 0;
      end else begin
         commit   = 0;
         boundary = en && (!mRunning || mPos == FRAME - 1);
         if (load) begin
            mStData = data;
            mStMask = mask;
            mPend   = 1;
         end
         if (boundary && mPend) begin
            mShData = mStData;
            mShMask = mStMask;
            mPend   = 0;
            commit  = 1;
         end
         if (!en) begin
            mRunning = 0;
            mPos     = 0;
         end else if (!mRunning) begin
            mRunning = 1;
            mPos     = 0;
         end else begin
            mPos = (mPos + 1) % FRAME;
         end
         mAckNext = commit;
      end
   endtask

   task automatic applyStimulus(input bit rstN, input bit en, input bit load,
                                input logic [15:0] data, input logic [3:0] mask);
      @(negedge iCLK);
      iRST_N = rstN;
      iEN    = en;
      iLOAD  = load;
      iDATA  = data;
      iMASK  = mask;
      expQ.push_back(predictOutputs(rstN));
      modelStep(rstN, en, load, data, mask);
   endtask

   task automatic idle(input int n, input bit en = 1'b1);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b1, en, 1'b0, 16'($urandom), 4'($urandom));
      end
   endtask

   task automatic waitForPos(input int target);
      int guard;
      guard = 0;
      while (!(mRunning && mPos == target) && guard < 3 * FRAME) begin
         idle(1);
         guard++;
      end
      if (!(mRunning && mPos == target)) begin
         miscompares++;
         $display("[TB] FAIL waitForPos: position %0d, required %0d", mPos, target);
      end
   endtask

   task automatic checkOutput();
      exp_t e;
      exp_t act;
      e         = expQ.pop_front();
      act.an    = oAN;
      act.seg   = oSEG;
      act.frame = oFRAME;
      act.ack   = oACK;
      act.busy  = oBUSY;
      vectors++;
      if (act !== e) begin
         miscompares++;
         $display("[TB] FAIL outputs cycle %0d: an=%b seg=%b frame=%b ack=%b busy=%b, required an=%b seg=%b frame=%b ack=%b busy=%b",
                  cycle, act.an, act.seg, act.frame, act.ack, act.busy,
                  e.an, e.seg, e.frame, e.ack, e.busy);
      end
   endtask

   // Monitor: every registered output update is compared against the queue head
   initial begin
      forever begin
         @(posedge iCLK);
         #1;
         cycle++;
         if (expQ.size() != 0) begin
            checkOutput();
         end
      end
   end

   initial begin
      iRST_N = 1'b0;
      iEN    = 1'b1;
      iLOAD  = 1'b0;
      iDATA  = '0;
      iMASK  = '0;

      $display("[TB] reset with enable high");
      repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 16'($urandom), 4'($urandom));
      idle(40);

      $display("[TB] normal scan of 3A70");
      applyStimulus(1'b1, 1'b1, 1'b1, 16'h3A70, 4'b0000);
      idle(70);

      $display("[TB] mid-frame reload");
      waitForPos(3);
      applyStimulus(1'b1, 1'b1, 1'b1, 16'h1111, 4'b0000);
      waitForPos(2 * DIV + 3);
      applyStimulus(1'b1, 1'b1, 1'b1, 16'h2222, 4'b0000);
      idle(70);

      $display("[TB] load on the boundary edge");
      waitForPos(FRAME - 1);
      applyStimulus(1'b1, 1'b1, 1'b1, 16'h5555, 4'b0000);
      idle(40);

      $display("[TB] masked digit 2");
      applyStimulus(1'b1, 1'b1, 1'b1, 16'h3A70, 4'b0100);
      idle(70);

      $display("[TB] enable drop and mid-load reset");
      waitForPos(3 * DIV + 3);
      idle(5, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 16'hBEEF, 4'b0000);
      idle(40);
      waitForPos(DIV + 4);
      applyStimulus(1'b1, 1'b1, 1'b1, 16'h9876, 4'b0000);
      idle(3);
      applyStimulus(1'b0, 1'b1, 1'b0, 16'($urandom), 4'($urandom));
      idle(70);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 1500; i++) begin
         applyStimulus($urandom_range(0, 99) != 0,
                       $urandom_range(0, 19) != 0,
                       $urandom_range(0, 9) == 0,
                       16'($urandom),
                       ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000);
      end

      @(posedge iCLK);
      #3;
      if (expQ.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL drain: %0d predictions left, required 0", expQ.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
